// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - pipeline/memory signal bundle for the shared memory port arbiter
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall_fetch;
    logic        stall_mem;

    // master: pipeline stages plus the memory array, i.e. everything around the arbiter
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_valid, d_rdata, d_valid,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall_fetch, stall_mem
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_valid, d_rdata, d_valid,
        output mem_en, mem_we, mem_addr, mem_wdata, stall_fetch, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one single-port memory with starvation guard
module mem_port_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    mem_port_arbiter_if.slave bus
);
    localparam int              SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [3:0]      LAT_INIT   = 4'(MEM_LAT);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
            $error("mem_port_arbiter: MEM_LAT=%0d outside 1..15", MEM_LAT);
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state, state_nxt;
    logic            owner_d;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic            we_q;
    logic [3:0]      lat_cnt;
    logic [SW-1:0]   starve_cnt;
    logic [31:0]     if_rdata_q;
    logic [31:0]     d_rdata_q;
    logic            starved;
    logic            grant_any;
    logic            grant_d;

    always_comb begin
        starved   = (starve_cnt == STARVE_LIM);
        grant_any = bus.if_req | bus.d_req;
        grant_d   = bus.d_req & ~(bus.if_req & starved);
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (lat_cnt == 4'd1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            owner_d    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner_d <= grant_d;
                        addr_q  <= grant_d ? bus.d_addr : bus.if_addr;
                        we_q    <= grant_d & bus.d_we;
                        wdata_q <= grant_d ? bus.d_wdata : '0;
                        // only a data grant that overtakes a waiting fetch counts as starvation
                        if (!grant_d)
                            starve_cnt <= '0;
                        else if (bus.if_req && !starved)
                            starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                ISSUE: lat_cnt <= LAT_INIT;
                WAIT: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    if (lat_cnt == 4'd1 && !we_q) begin
                        if (owner_d)
                            d_rdata_q <= bus.mem_rdata;
                        else
                            if_rdata_q <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_en    = (state == ISSUE);
    assign bus.mem_we    = (state == ISSUE) & we_q;
    assign bus.mem_addr  = (state == ISSUE) ? addr_q  : '0;
    assign bus.mem_wdata = (state == ISSUE) ? wdata_q : '0;
    assign bus.if_valid  = (state == DONE) & ~owner_d;
    assign bus.d_valid   = (state == DONE) &  owner_d;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    // gated by reset so every output reads 0 while the block is held in reset
    assign bus.stall_fetch = reset & bus.if_req & ~bus.if_valid;
    assign bus.stall_mem   = reset & bus.d_req  & ~bus.d_valid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic reset3;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    mem_port_arbiter_if b1();
    mem_port_arbiter_if b3();

    mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(STARVE_MAX)) u_dut1 (.clk(clk), .reset(reset),  .bus(b1));
    mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(STARVE_MAX)) u_dut3 (.clk(clk), .reset(reset3), .bus(b3));

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hDEAD_BEEF : 32'hA000_0000 + 32'(i);
    endfunction

    // memory models: read data is only presented in the exact cycle it is due
    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];
    logic [31:0] pend1 = '0;
    logic [31:0] pend3 = '0;
    int          cnt1 = 0;
    int          cnt3 = 0;

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) mem1[i] <= init_word(i);
            cnt1 <= 0;
        end else begin
            if (cnt1 > 0) cnt1 <= cnt1 - 1;
            if (b1.mem_en) begin
                if (b1.mem_we) mem1[b1.mem_addr[9:2]] <= b1.mem_wdata;
                else           pend1 <= mem1[b1.mem_addr[9:2]];
                cnt1 <= 1;
            end
        end
    end
    assign b1.mem_rdata = (cnt1 == 1) ? pend1 : 32'hBAD0_0BAD;

    always @(posedge clk) begin
        if (!reset3) begin
            for (int i = 0; i < 256; i++) mem3[i] <= init_word(i);
            cnt3 <= 0;
        end else begin
            if (cnt3 > 0) cnt3 <= cnt3 - 1;
            if (b3.mem_en) begin
                if (b3.mem_we) mem3[b3.mem_addr[9:2]] <= b3.mem_wdata;
                else           pend3 <= mem3[b3.mem_addr[9:2]];
                cnt3 <= 3;
            end
        end
    end
    assign b3.mem_rdata = (cnt3 == 1) ? pend3 : 32'hBAD0_0BAD;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit          fetch;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] data;
        bit          lat;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
    } req_t;

    exp_t        exp_q[$];
    req_t        fq[$];
    req_t        dq[$];
    bit          f_act = 0, d_act = 0, f_seen = 0, d_seen = 0;
    int          f_req_cyc = 0;
    logic [31:0] last_d = '0;
    logic [31:0] last_f = '0;

    task automatic req_d(input logic [31:0] addr, input bit we, input logic [31:0] wdata);
        req_t r;
        r.addr = addr; r.we = we; r.wdata = wdata;
        dq.push_back(r);
    endtask

    task automatic req_f(input logic [31:0] addr);
        req_t r;
        r.addr = addr; r.we = 1'b0; r.wdata = '0;
        fq.push_back(r);
    endtask

    // expected completions, called in the grant order worked out by hand
    task automatic exp_d(input logic [31:0] addr, input bit we, input logic [31:0] wdata, input logic [31:0] rd);
        exp_t e;
        if (!we) last_d = rd;
        e.fetch = 1'b0; e.we = we; e.addr = addr; e.wdata = we ? wdata : '0;
        e.data = last_d; e.lat = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic exp_f(input logic [31:0] addr, input logic [31:0] rd, input bit lat);
        exp_t e;
        last_f = rd;
        e.fetch = 1'b1; e.we = 1'b0; e.addr = addr; e.wdata = '0;
        e.data = last_f; e.lat = lat;
        exp_q.push_back(e);
    endtask

    // requesters: hold req until valid, drop or re-issue at the edge ending the valid cycle
    initial begin
        req_t r;
        b1.if_req = 0; b1.if_addr = '0;
        b1.d_req = 0; b1.d_we = 0; b1.d_addr = '0; b1.d_wdata = '0;
        forever begin
            @(posedge clk); #1;
            if (f_act && f_seen) begin f_act = 0; b1.if_req = 0; end
            if (!f_act && fq.size() > 0) begin
                r = fq.pop_front();
                b1.if_addr = r.addr; b1.if_req = 1; f_act = 1; f_req_cyc = cyc;
            end
            if (d_act && d_seen) begin d_act = 0; b1.d_req = 0; end
            if (!d_act && dq.size() > 0) begin
                r = dq.pop_front();
                b1.d_addr = r.addr; b1.d_we = r.we; b1.d_wdata = r.wdata; b1.d_req = 1; d_act = 1;
            end
        end
    end

    // monitor for DUT1
    int          men_cyc = 0;
    logic        men_we = 0;
    logic [31:0] men_addr = '0;
    logic [31:0] men_wdata = '0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            f_seen = b1.if_valid;
            d_seen = b1.d_valid;
            if (reset) begin
                chk("stall_fetch", 32'(b1.stall_fetch), 32'(b1.if_req & ~b1.if_valid));
                chk("stall_mem",   32'(b1.stall_mem),   32'(b1.d_req & ~b1.d_valid));
                if (b1.mem_en) begin
                    men_cyc = cyc; men_we = b1.mem_we; men_addr = b1.mem_addr; men_wdata = b1.mem_wdata;
                end else begin
                    chk("mem_idle_zero", b1.mem_addr | b1.mem_wdata | 32'(b1.mem_we), 32'h0);
                end
                if (b1.if_valid || b1.d_valid) begin
                    chk("single_valid", 32'(b1.if_valid & b1.d_valid), 32'h0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", 32'(1), 32'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("owner_is_fetch", 32'(b1.if_valid), 32'(e.fetch));
                        chk("rdata", e.fetch ? b1.if_rdata : b1.d_rdata, e.data);
                        chk("mem_addr", men_addr, e.addr);
                        chk("mem_we", 32'(men_we), 32'(e.we));
                        chk("mem_wdata", men_wdata, e.wdata);
                        chk("en_to_valid", 32'(cyc - men_cyc), 32'(2));
                        if (e.lat) chk("req_to_valid", 32'(cyc - f_req_cyc), 32'(3));
                    end
                end
            end
        end
    end

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || fq.size() != 0 || dq.size() != 0 || f_act || d_act) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", 32'(n < 300), 32'(1));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        reset = 0; reset3 = 0;
        b3.if_req = 0; b3.if_addr = '0;
        b3.d_req = 0; b3.d_we = 0; b3.d_addr = '0; b3.d_wdata = '0;

        // reset held with both requests pending
        @(negedge clk);
        req_d(32'h20, 1'b0, '0);
        req_f(32'h30);
        exp_d(32'h20, 1'b0, '0, 32'hA000_0008);
        exp_f(32'h30, 32'hA000_000C, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("reset_ctrl", 32'({b1.mem_en, b1.mem_we, b1.if_valid, b1.d_valid, b1.stall_fetch, b1.stall_mem}), 32'h0);
            chk("reset_data", b1.mem_addr | b1.mem_wdata | b1.if_rdata | b1.d_rdata, 32'h0);
        end
        @(posedge clk); #1 reset = 1;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (b1.d_valid) break;
        end
        chk("first_grant_latency", 32'(n), 32'(4));
        wait_drain();

        // lone fetch, latency measured from req
        req_f(32'h10);
        exp_f(32'h10, 32'hDEAD_BEEF, 1'b1);
        wait_drain();

        // simultaneous requests: data write first, fetch reads the written word
        req_d(32'h40, 1'b1, 32'h1234);
        req_f(32'h40);
        exp_d(32'h40, 1'b1, 32'h1234, '0);
        exp_f(32'h40, 32'h0000_1234, 1'b0);
        wait_drain();

        // starvation guard
        for (int i = 0; i < 6; i++) req_d(32'h100 + 32'(4 * i), 1'b0, '0);
        req_f(32'h200);
        req_f(32'h204);
        for (int i = 0; i < 4; i++) exp_d(32'h100 + 32'(4 * i), 1'b0, '0, 32'hA000_0040 + 32'(i));
        exp_f(32'h200, 32'hA000_0080, 1'b0);
        exp_d(32'h110, 1'b0, '0, 32'hA000_0044);
        exp_d(32'h114, 1'b0, '0, 32'hA000_0045);
        exp_f(32'h204, 32'hA000_0081, 1'b0);
        wait_drain();

        // write/read round trip; writes leave d_rdata untouched
        req_d(32'h80, 1'b1, 32'hCAFE_F00D);
        req_d(32'h80, 1'b0, '0);
        req_d(32'h84, 1'b1, 32'h0000_55AA);
        req_f(32'h84);
        exp_d(32'h80, 1'b1, 32'hCAFE_F00D, '0);
        exp_d(32'h80, 1'b0, '0, 32'hCAFE_F00D);
        exp_d(32'h84, 1'b1, 32'h0000_55AA, '0);
        exp_f(32'h84, 32'h0000_55AA, 1'b0);
        wait_drain();

        // MEM_LAT=3 instance: reset during WAIT aborts the access
        @(posedge clk); #1 reset3 = 1;
        @(posedge clk); #1 b3.d_req = 1; b3.d_we = 0; b3.d_addr = 32'h24;
        @(negedge clk);
        @(negedge clk);
        chk("lat3_issue", 32'(b3.mem_en), 32'(1));
        @(posedge clk); #1 reset3 = 0; b3.d_req = 0;
        repeat (5) begin
            @(negedge clk);
            chk("lat3_abort_quiet", 32'({b3.d_valid, b3.if_valid, b3.mem_en}), 32'h0);
        end
        chk("lat3_abort_rdata", b3.d_rdata, 32'h0);
        @(posedge clk); #1 reset3 = 1;
        @(posedge clk); #1 b3.d_req = 1; b3.d_addr = 32'h28;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (b3.d_valid) break;
        end
        chk("lat3_latency", 32'(n), 32'(6));
        chk("lat3_rdata", b3.d_rdata, 32'hA000_000A);
        @(posedge clk); #1 b3.d_req = 0;
        repeat (3) @(negedge clk);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
